// File: rtl/ti_i2s_tx_if.sv
// ---------------------------------------------------------------------------
// ti_i2s_tx_if
// Sample handshake between the SN76489 tone/noise mixer (producer) and the
// I2S transmitter (consumer).
//   sample       : 15-bit unsigned mixer sample (0..32767)
//   sample_valid : producer presents a sample
//   sample_ready : consumer holding register is empty
// A transfer happens on a CLK edge where sample_valid && sample_ready.
// Modports: master = mixer side, slave = transmitter side.
// ---------------------------------------------------------------------------
interface ti_i2s_tx_if;
    logic [14:0] sample;
    logic        sample_valid;
    logic        sample_ready;

    modport master (output sample, output sample_valid, input sample_ready);
    modport slave  (input sample, input sample_valid, output sample_ready);
endinterface

// File: rtl/ti_i2s_tx.sv
// ---------------------------------------------------------------------------
// ti_i2s_tx
// Serial audio transmitter for the TI_SN76489 sound core. Each accepted
// 15-bit unsigned mixer sample is converted to 16-bit two's-complement PCM,
// {~s[14], s[13:0], 1'b0}, and sent in both slots of a 32-bit stereo frame.
// A one-entry holding register decouples the mixer rate from the frame rate;
// a frame that starts without a fresh sample repeats the last one and raises
// a one-cycle underrun pulse.
//
// Parameters:
//   CLK_DIV : CLK cycles per BCLK half-period (>= 1)
// Build option:
//   TI_I2S_LJ_EN defined   -> left-justified (MSB aligned with LRCLK edge)
//   TI_I2S_LJ_EN undefined -> standard I2S (MSB one BCLK after LRCLK edge)
// Ports:
//   CLK      : system clock, all logic on posedge
//   nRST     : asynchronous active-low reset
//   smp      : sample handshake (slave side of ti_i2s_tx_if)
//   BCLK     : bit clock
//   LRCLK    : word select, 0 = left slot, 1 = right slot
//   SDATA    : serial data, MSB first
//   underrun : one-cycle pulse when a frame loads without a new sample
// All outputs are registered (sample_ready is the inverse of a register).
// ---------------------------------------------------------------------------
module ti_i2s_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic         CLK,
    input  logic         nRST,
    ti_i2s_tx_if.slave   smp,
    output logic         BCLK,
    output logic         LRCLK,
    output logic         SDATA,
    output logic         underrun
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [14:0] PCM_ZERO_CODE = 15'd16384;

    logic [DIV_W-1:0] div_cnt;
    logic [4:0]       bit_cnt;
    logic [14:0]      hold;
    logic             full;
    logic [31:0]      frame;

    logic             div_tc;
    logic             fall;
    logic             load;
    logic             xfer;
    logic [4:0]       bit_nxt;
    logic [15:0]      pcm;
    logic [31:0]      frame_nxt;
    logic [4:0]       sd_idx;
    logic             sdata_nxt;

    assign div_tc    = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign fall      = div_tc & BCLK;
    assign bit_nxt   = bit_cnt + 5'd1;
    // The frame loads on the falling event that wraps bit_cnt 31 -> 0.
    assign load      = fall & (bit_cnt == 5'd31);
    assign xfer      = smp.sample_valid & ~full;
    assign pcm       = {~hold[14], hold[13:0], 1'b0};
    assign frame_nxt = load ? {pcm, pcm} : frame;

    assign smp.sample_ready = ~full;

    // Bit selection for the slot position that the new bit_cnt points at.
    // NOTE: every signal written in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        sd_idx    = 5'd0;
        sdata_nxt = 1'b0;
`ifdef TI_I2S_LJ_EN
        // MSB on the LRCLK edge: bit 31-k of the (possibly just loaded) frame.
        sd_idx    = ~bit_nxt;
        sdata_nxt = frame_nxt[sd_idx];
`else
        // One-bit delay: 32-k wraps to 0 at k=0, which selects bit 0 of the
        // frame still in the register, i.e. the previous frame's last bit.
        sd_idx    = 5'd0 - bit_nxt;
        sdata_nxt = frame[sd_idx];
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side sees pre-edge values; this is what makes a same-cycle
    // transfer and frame load use the old hold/full.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            div_cnt  <= '0;
            bit_cnt  <= 5'd31;
            BCLK     <= 1'b0;
            LRCLK    <= 1'b0;
            SDATA    <= 1'b0;
            underrun <= 1'b0;
            frame    <= '0;
            // Reset to the PCM-zero code so an early underrun sends silence.
            hold     <= PCM_ZERO_CODE;
            full     <= 1'b0;
        end else begin
            underrun <= 1'b0;

            if (div_tc) begin
                div_cnt <= '0;
                BCLK    <= ~BCLK;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end

            if (fall) begin
                bit_cnt <= bit_nxt;
                LRCLK   <= bit_nxt[4];
                SDATA   <= sdata_nxt;
            end

            if (load) begin
                frame    <= frame_nxt;
                underrun <= ~full;
            end

            // A transfer in the load cycle wins: the new sample stays held
            // for the next frame.
            if (xfer) begin
                hold <= smp.sample;
                full <= 1'b1;
            end else if (load) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ti_i2s_tx.sv
// ---------------------------------------------------------------------------
// tb_ti_i2s_tx
// Self-checking bench for ti_i2s_tx with CLK_DIV = 2. A behavioural model
// derives BCLK, bit position and frame boundaries from the cycle count since
// reset release and predicts every output on every cycle.
// ---------------------------------------------------------------------------
module tb_ti_i2s_tx;

    localparam int D = 2;

    logic CLK  = 1'b0;
    logic nRST = 1'b1;
    logic BCLK, LRCLK, SDATA, underrun;

    ti_i2s_tx_if smp ();

    ti_i2s_tx #(.CLK_DIV(D)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .smp      (smp),
        .BCLK     (BCLK),
        .LRCLK    (LRCLK),
        .SDATA    (SDATA),
        .underrun (underrun)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int          t;          // posedges since reset release
    int          m_k;        // current bit position
    logic [14:0] m_hold;
    bit          m_full;
    logic [31:0] m_word;
    logic        e_bclk, e_lr, e_sd, e_ur;
    bit          last_xfer;
    int          ur_seen;

    function automatic logic [15:0] to_pcm(int s);
        return 16'((s - 16384) * 2);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    task automatic model_reset();
        t = 0; m_k = 31; m_hold = 15'd16384; m_full = 0; m_word = '0;
        e_bclk = 0; e_lr = 0; e_sd = 0; e_ur = 0; last_xfer = 0;
    endtask

    task automatic check_outputs();
        chk("BCLK", 32'(BCLK), 32'(e_bclk));
        chk("LRCLK", 32'(LRCLK), 32'(e_lr));
        chk("SDATA", 32'(SDATA), 32'(e_sd));
        chk("underrun", 32'(underrun), 32'(e_ur));
        chk("sample_ready", 32'(smp.sample_ready), 32'(!m_full));
    endtask

    task automatic tick();
        bit xfer, fall;
        int k;
        logic [31:0] old;
        @(posedge CLK);
        t++;
        xfer   = smp.sample_valid && !m_full;
        fall   = (t % (2 * D)) == 0;
        e_bclk = ((t / D) % 2) == 1;
        e_ur   = 0;
        if (fall) begin
            k   = (t / (2 * D) - 1) % 32;
            m_k = k;
            old = m_word;
            if (k == 0) begin
                m_word = {to_pcm(int'(m_hold)), to_pcm(int'(m_hold))};
                e_ur   = !m_full;
                m_full = 0;
            end
            e_lr = (k >= 16);
`ifdef TI_I2S_LJ_EN
            e_sd = m_word[31 - k];
`else
            e_sd = (k == 0) ? old[0] : m_word[32 - k];
`endif
        end
        if (xfer) begin
            m_hold = smp.sample;
            m_full = 1;
        end
        last_xfer = xfer;
        #1;
        if (underrun === 1'b1) ur_seen++;
        check_outputs();
    endtask

    task automatic idle(int n);
        smp.sample_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Present a sample (valid stays high afterwards) until it is accepted.
    task automatic send(int s);
        bit done;
        done = 0;
        smp.sample       = 15'(s);
        smp.sample_valid = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            tick();
            done = last_xfer;
        end
        if (!done) begin
            tests++; fails++;
            $error("FAIL send_timeout t=%0d observed=0 expected=1", t);
        end
    endtask

    task automatic reset_now();
        smp.sample_valid = 1'b0;
        nRST = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin
        smp.sample       = '0;
        smp.sample_valid = 1'b0;
        model_reset();
        #2;
        reset_now();

        // No samples: PCM-zero frames, underrun every frame start.
        ur_seen = 0;
        idle(300);
        chk("underrun_count", 32'(ur_seen), 32'd3);

        // Full-scale sample loaded into the first frame, no underrun there.
        reset_now();
        ur_seen = 0;
        send(32767);
        idle(130);
        chk("no_underrun_first", 32'(ur_seen), 32'd0);
        idle(130);

        // Back-to-back with valid held high: second waits for the load.
        send(0);
        send(16384);
        idle(270);

        // Transfer on the exact frame-load edge.
        while ((t + 1) % (64 * D) != 2 * D) tick();
        smp.sample       = 15'd12345;
        smp.sample_valid = 1'b1;
        tick();
        smp.sample_valid = 1'b0;
        chk("full_across_load", 32'(smp.sample_ready), 32'd0);
        idle(270);

        // Reset mid-frame with a held sample.
        send(5000);
        smp.sample_valid = 1'b0;
        for (int i = 0; i < 300 && m_k != 10; i++) tick();
        chk("reached_k10", 32'(m_k), 32'd10);
        #2;
        reset_now();
        ur_seen = 0;
        idle(140);
        chk("underrun_after_reset", 32'(ur_seen), 32'd2);

        // Randomised traffic.
        for (int n = 0; n < 14; n++) begin
            send(int'($urandom_range(0, 32767)));
            if ($urandom_range(0, 1) == 1) send(int'($urandom_range(0, 32767)));
            idle(int'($urandom_range(0, 180)));
        end
        send(0);
        send(32767);
        idle(260);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
